// File: rtl/fa_response_checker_if.sv
// Handshake bundle between the vector source and the full-adder response checker.
// The source drives the sample and start strobes; the checker drives the verdict.
interface fa_response_checker_if #(
   parameter int ERR_W = 8
);
   logic             start;
   logic             in_valid;
   logic             a;
   logic             b;
   logic             c;
   logic             y;
   logic             co;
   logic             busy;
   logic             done;
   logic             pass;
   logic             timed_out;
   logic [ERR_W-1:0] err_cnt;
   logic [7:0]       seen;
   logic [4:0]       first_fail;
   logic             first_fail_vld;

   modport master (
      output start, in_valid, a, b, c, y, co,
      input  busy, done, pass, timed_out, err_cnt, seen, first_fail, first_fail_vld
   );

   modport slave (
      input  start, in_valid, a, b, c, y, co,
      output busy, done, pass, timed_out, err_cnt, seen, first_fail, first_fail_vld
   );
endinterface

// File: rtl/fa_response_checker.sv
// Checks full-adder responses against the golden function, tracks coverage of the
// 8 input combinations, counts mismatches and reports a registered pass/fail verdict.
module fa_response_checker #(
   parameter int ERR_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   fa_response_checker_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
   localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

   // Sample layout is {a,b,c,y,co}; true when the response disagrees with the golden adder.
   function automatic logic fa_mismatch(input logic [4:0] smp);
      logic sum_v;
      logic carry_v;
      sum_v   = smp[4] ^ smp[3] ^ smp[2];
      carry_v = (smp[4] & smp[3]) | (smp[4] & smp[2]) | (smp[3] & smp[2]);
      return (smp[1] != sum_v) || (smp[0] != carry_v);
   endfunction

   state_t           state_r;
   logic [15:0]      cnt_r;
   logic [ERR_W-1:0] err_cnt_r;
   logic [7:0]       seen_r;
   logic [4:0]       first_fail_r;
   logic             first_fail_vld_r;
   logic             pass_r;
   logic             timed_out_r;
   logic             busy_r;
   logic             done_r;

   logic [2:0]       vec_s;
   logic [4:0]       sample_s;
   logic             fail_hit_s;
   logic [7:0]       seen_next_s;
   logic [ERR_W-1:0] err_next_s;

   // Next-state view of coverage and error count including the current sample.
   always_comb begin
      vec_s      = {bus.a, bus.b, bus.c};
      sample_s   = {vec_s, bus.y, bus.co};
      fail_hit_s = bus.in_valid && fa_mismatch(sample_s);
      if (bus.in_valid) begin
         seen_next_s = seen_r | (8'b0000_0001 << vec_s);
      end else begin
         seen_next_s = seen_r;
      end
      if (fail_hit_s && (err_cnt_r != ERR_MAX)) begin
         err_next_s = err_cnt_r + ERR_W'(1);
      end else begin
         err_next_s = err_cnt_r;
      end
   end

   // Session FSM; start from any state restarts with clears and drops that cycle's sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r          <= IDLE;
         cnt_r            <= 16'd0;
         err_cnt_r        <= '0;
         seen_r           <= 8'h00;
         first_fail_r     <= 5'b00000;
         first_fail_vld_r <= 1'b0;
         pass_r           <= 1'b0;
         timed_out_r      <= 1'b0;
         busy_r           <= 1'b0;
         done_r           <= 1'b0;
      end else if (bus.start) begin
         state_r          <= RUN;
         cnt_r            <= 16'd0;
         err_cnt_r        <= '0;
         seen_r           <= 8'h00;
         first_fail_r     <= 5'b00000;
         first_fail_vld_r <= 1'b0;
         pass_r           <= 1'b0;
         timed_out_r      <= 1'b0;
         busy_r           <= 1'b1;
         done_r           <= 1'b0;
      end else begin
         case (state_r)
            RUN: begin
               seen_r    <= seen_next_s;
               err_cnt_r <= err_next_s;
               cnt_r     <= cnt_r + 16'd1;
               if (fail_hit_s && !first_fail_vld_r) begin
                  first_fail_r     <= sample_s;
                  first_fail_vld_r <= 1'b1;
               end
               // Coverage is checked first so a simultaneous timeout is not flagged.
               if (seen_next_s == 8'hFF) begin
                  state_r     <= DONE;
                  busy_r      <= 1'b0;
                  done_r      <= 1'b1;
                  pass_r      <= (err_next_s == '0);
                  timed_out_r <= 1'b0;
               end else if (cnt_r == TMO_LAST) begin
                  state_r     <= DONE;
                  busy_r      <= 1'b0;
                  done_r      <= 1'b1;
                  pass_r      <= 1'b0;
                  timed_out_r <= 1'b1;
               end
            end
            IDLE: begin
               state_r <= IDLE;
            end
            DONE: begin
               state_r <= DONE;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy           = busy_r;
   assign bus.done           = done_r;
   assign bus.pass           = pass_r;
   assign bus.timed_out      = timed_out_r;
   assign bus.err_cnt        = err_cnt_r;
   assign bus.seen           = seen_r;
   assign bus.first_fail     = first_fail_r;
   assign bus.first_fail_vld = first_fail_vld_r;
endmodule

// File: doc/fa_response_checker.md
# fa_response_checker

- Sequential response checker that is the receiving end of the full-adder exhaustive-vector flow.
- Each valid cycle it samples the applied vector {a,b,c} and the DUT's sum/carry, and compares them against the golden full-adder function.
- It tracks which of the 8 input combinations have been exercised, counts mismatches and captures the first failing vector.
- It ends with a pass/fail verdict, either when all 8 combinations have been covered or when the session times out.

## Interface
- ERR_W, 8: width of mismatch counter (saturating).
- TIMEOUT, 64: maximum RUN-state cycles before the session is forced to DONE; legal range 8..65535.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; clears results and begins a session.
- in_valid  in  1  sample strobe for a, b, c, y, co.
- a, b, c  in  1 each  vector applied to the DUT.
- y  in  1  DUT sum output.
- co  in  1  DUT carry output.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- pass  out  1  registered verdict.
- timed_out  out  1  session ended by TIMEOUT.
- err_cnt  out  ERR_W  mismatch count.
- seen  out  8  coverage bitmap; bit index = {a,b,c}.
- first_fail  out  5  {a,b,c,y,co} of the first mismatching sample.
- first_fail_vld  out  1  first_fail holds valid data.

## Operation
- States: IDLE, RUN, DONE.
- Reset, asynchronous: state=IDLE and every output = 0, including the internal cycle counter.
- Golden model:
  - sum = a^b^c.
  - carry = (a&b)|(a&c)|(b&c).
  - A sample mismatches if y != sum or co != carry.
- IDLE -> RUN on start. On entry: err_cnt, seen, first_fail, first_fail_vld, pass, timed_out and the cycle counter are cleared.
- RUN, on each cycle with in_valid=1:
  - Set seen[{a,b,c}].
  - If the sample mismatches:
    - err_cnt increments, saturating at 2^ERR_W-1.
    - If first_fail_vld=0, load first_fail and set first_fail_vld.
  - Repeated vectors are legal, and every repeat is checked.
- RUN cycle counter counts every RUN cycle, valid or not, starting at 0 on entry.
- RUN -> DONE, evaluated including the current cycle's sample:
  - When seen becomes 8'hFF.
  - Otherwise when the counter equals TIMEOUT-1; this path sets timed_out=1.
- Simultaneous completion and timeout: coverage wins, so timed_out=0.
- pass is set on entry to DONE as: err_cnt==0 and seen==8'hFF, both including the final sample.
- DONE:
  - Holds all results.
  - in_valid is ignored.
  - start restarts the session (-> RUN with clears).
- start while in RUN: restarts immediately (clears, stays in RUN). A sample presented on the same cycle as start is discarded.
- in_valid while in IDLE is ignored.

## Timing
- Outputs are registered: a sample presented at edge N is reflected in seen, err_cnt and first_fail after edge N.
- The completing sample at edge N gives done=1, busy=0 and a valid pass after edge N, i.e. zero extra latency.
- busy rises the cycle after the start edge.
- Timeout: with start sampled at edge S, done rises after edge S+TIMEOUT if coverage is incomplete.
- Back-to-back in_valid every cycle is supported; no backpressure.
- Reset asserted mid-RUN clears everything asynchronously. After release, the block waits in IDLE for start.

## Test plan
- Correct DUT model, vectors 000..111 on consecutive cycles after start:
  - done after the 8th sample.
  - pass=1, err_cnt=0, seen=8'hFF, first_fail_vld=0, timed_out=0.
- Sum stuck-at-0 (y=0, co correct), exhaustive vectors:
  - err_cnt=4, first_fail=5'b00100, first_fail_vld=1, pass=0, seen=8'hFF.
- TIMEOUT=16, only vectors 000..110 applied, then in_valid low:
  - done asserted 16 cycles after start.
  - timed_out=1, seen=8'h7F, pass=0, err_cnt=0.
- ERR_W=2, co inverted on all 8 vectors:
  - err_cnt saturates at 3.
  - first_fail=5'b00001, pass=0.
- Restart and reset mid-run:
  - 3 samples, then start with a sample in the same cycle: seen=8'h00, err_cnt=0 the next cycle, busy=1.
  - A subsequent full sweep gives pass=1.
  - rst pulsed mid-RUN: all outputs 0 immediately; in_valid ignored until start.
